// File: rtl/jtdsp16_pkg.sv
// Shared constants for the jtdsp16 address arithmetic units:
// Y-field post-modify modes, register-select codes and default address width.
package jtdsp16_pkg;

  localparam int AW_DEF = 16;

  typedef enum logic [1:0] {
    YM_NONE = 2'd0,
    YM_INC  = 2'd1,
    YM_DEC  = 2'd2,
    YM_INCJ = 2'd3
  } ymode_e;

  localparam logic [2:0] RF_R0 = 3'd0;
  localparam logic [2:0] RF_R1 = 3'd1;
  localparam logic [2:0] RF_R2 = 3'd2;
  localparam logic [2:0] RF_R3 = 3'd3;
  localparam logic [2:0] RF_J  = 3'd4;
  localparam logic [2:0] RF_K  = 3'd5;
  localparam logic [2:0] RF_RB = 3'd6;
  localparam logic [2:0] RF_RE = 3'd7;

endpackage

// File: rtl/jtdsp16_yaau_next.sv
// Combinational next-pointer calculator: applies one post-modify mode to a
// pointer, including the circular wrap from re back to rb on increments.
module jtdsp16_yaau_next
  import jtdsp16_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] ptr,
  input  ymode_e        mode,
  input  logic [AW-1:0] j,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] re,
  output logic [AW-1:0] nxt
);

  always_comb begin
    nxt = ptr;
    case (mode)
      YM_NONE: nxt = ptr;
      YM_INC: begin
        // re==0 disables the circular buffer entirely
        if (re != '0 && ptr == re) nxt = rb;
        else                       nxt = ptr + AW'(1);
      end
      YM_DEC:  nxt = ptr - AW'(1);
      YM_INCJ: nxt = ptr + j;
    endcase
  end

endmodule

// File: rtl/jtdsp16_yaau.sv
// Y-space address arithmetic unit: pointer registers r0-r3, increment j/k,
// circular bounds rb/re; zero-latency RAM address with post-modify on access.
module jtdsp16_yaau
  import jtdsp16_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          acc_en,
  input  logic [3:0]    y_field,
  input  logic [2:0]    r_field,
  input  logic          ram_load,
  input  logic          imm_load,
  input  logic          short_load,
  input  logic [15:0]   ram_dout,
  input  logic [15:0]   long_imm,
  input  logic [8:0]    short_imm,
  output logic [AW-1:0] ram_addr,
  output logic [15:0]   reg_dout
);

  logic [AW-1:0] r_q [4];
  logic [AW-1:0] r_d [4];
  logic [AW-1:0] j_q, j_d, k_q, k_d, rb_q, rb_d, re_q, re_d;

  logic [1:0]    sel;
  ymode_e        mode;
  logic [AW-1:0] nxt_ptr;
  logic          load_any;
  logic [AW-1:0] load_val;

  assign sel      = y_field[1:0];
  assign mode     = ymode_e'(y_field[3:2]);
  assign ram_addr = r_q[sel];

  jtdsp16_yaau_next #(.AW(AW)) u_next (
    .ptr  (r_q[sel]),
    .mode (mode),
    .j    (j_q),
    .rb   (rb_q),
    .re   (re_q),
    .nxt  (nxt_ptr)
  );

  assign load_any = imm_load | ram_load | short_load;

  always_comb begin
    load_val = AW'(short_imm);
    if (imm_load)      load_val = AW'(long_imm);
    else if (ram_load) load_val = AW'(ram_dout);
  end

  // Modify first, then the load overwrites it when both target one pointer
  always_comb begin
    r_d  = r_q;
    j_d  = j_q;
    k_d  = k_q;
    rb_d = rb_q;
    re_d = re_q;
    if (acc_en) r_d[sel] = nxt_ptr;
    if (load_any) begin
      case (r_field)
        RF_R0, RF_R1, RF_R2, RF_R3: r_d[r_field[1:0]] = load_val;
        RF_J:  j_d  = load_val;
        RF_K:  k_d  = load_val;
        RF_RB: rb_d = load_val;
        RF_RE: re_d = load_val;
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ptr
      always_ff @(posedge clk) begin
        if (rst)      r_q[gi] <= '0;
        else if (cen) r_q[gi] <= r_d[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      j_q  <= '0;
      k_q  <= '0;
      rb_q <= '0;
      re_q <= '0;
    end else if (cen) begin
      j_q  <= j_d;
      k_q  <= k_d;
      rb_q <= rb_d;
      re_q <= re_d;
    end
  end

  always_comb begin
    reg_dout = '0;
    case (r_field)
      RF_R0, RF_R1, RF_R2, RF_R3: reg_dout = 16'(r_q[r_field[1:0]]);
      RF_J:  reg_dout = 16'(j_q);
      RF_K:  reg_dout = 16'(k_q);
      RF_RB: reg_dout = 16'(rb_q);
      RF_RE: reg_dout = 16'(re_q);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jtdsp16_yaau.sv
// Self-checking bench for jtdsp16_yaau: directed vector table, hand-written
// cen/reset sequences, then randomized traffic against a register-file model.
module tb_jtdsp16_yaau;

  logic        clk = 1'b0;
  logic        rst, cen, acc_en, ram_load, imm_load, short_load;
  logic [3:0]  y_field;
  logic [2:0]  r_field;
  logic [15:0] ram_dout, long_imm;
  logic [8:0]  short_imm;
  logic [15:0] ram_addr, reg_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jtdsp16_yaau #(.AW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .acc_en     (acc_en),
    .y_field    (y_field),
    .r_field    (r_field),
    .ram_load   (ram_load),
    .imm_load   (imm_load),
    .short_load (short_load),
    .ram_dout   (ram_dout),
    .long_imm   (long_imm),
    .short_imm  (short_imm),
    .ram_addr   (ram_addr),
    .reg_dout   (reg_dout)
  );

  typedef struct {
    bit          acc;
    logic [3:0]  y;
    logic [2:0]  rf;
    bit          rl, il, sl;
    logic [15:0] rd, li;
    logic [8:0]  si;
    logic [15:0] ea, ed;
  } vec_t;

  vec_t tv[$];

  // Reference register file: index 0-3 r0-r3, 4 j, 5 k, 6 rb, 7 re
  logic [15:0] m [8];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input bit acc, input logic [3:0] y, input logic [2:0] rf,
                     input bit rl, input bit il, input bit sl,
                     input logic [15:0] rd, input logic [15:0] li, input logic [8:0] si,
                     input logic [15:0] ea, input logic [15:0] ed);
    vec_t v;
    v.acc = acc; v.y = y; v.rf = rf; v.rl = rl; v.il = il; v.sl = sl;
    v.rd = rd; v.li = li; v.si = si; v.ea = ea; v.ed = ed;
    tv.push_back(v);
  endtask

  task automatic drive(input bit ce, input bit acc, input logic [3:0] y, input logic [2:0] rf,
                       input bit rl, input bit il, input bit sl,
                       input logic [15:0] rd, input logic [15:0] li, input logic [8:0] si);
    cen = ce; acc_en = acc; y_field = y; r_field = rf;
    ram_load = rl; imm_load = il; short_load = sl;
    ram_dout = rd; long_imm = li; short_imm = si;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i] = 16'h0;
  endtask

  // Behavioural update of the reference register file for one clock edge
  task automatic model_edge();
    logic [15:0] nm [8];
    int unsigned p, s;
    for (int i = 0; i < 8; i++) nm[i] = m[i];
    if (rst) begin
      model_reset();
      return;
    end
    if (!cen) return;
    if (acc_en) begin
      s = y_field[1:0];
      p = m[s];
      case (y_field[3:2])
        2'd1: nm[s] = (m[7] != 0 && p == m[7]) ? m[6] : 16'((p + 1) % 65536);
        2'd2: nm[s] = 16'((p + 65535) % 65536);
        2'd3: nm[s] = 16'((p + m[4]) % 65536);
        default: ;
      endcase
    end
    if (imm_load)        nm[r_field] = long_imm;
    else if (ram_load)   nm[r_field] = ram_dout;
    else if (short_load) nm[r_field] = {7'd0, short_imm};
    for (int i = 0; i < 8; i++) m[i] = nm[i];
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      r_field = 3'(i);
      #1;
      chk($sformatf("%s reg%0d", tag, i), reg_dout, 16'h0);
    end
    for (int i = 0; i < 4; i++) begin
      y_field = 4'(i);
      #1;
      chk($sformatf("%s addr r%0d", tag, i), ram_addr, 16'h0);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 0, 4'h0, 3'd0, 0, 0, 0, 16'h0, 16'h0, 9'h0);
    tick();
    rst = 1'b0;
    model_reset();
    check_all_zero("reset");

    // Directed table: each row's expectations are the pre-edge outputs
    //   acc  y       rf  rl il sl  rd        li        si      ea        ed
    add(0, 4'b0000, 0, 0, 1, 0, 16'h0,    16'h0010, 9'h0,   16'h0000, 16'h0000);
    add(1, 4'b0100, 0, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'h0010, 16'h0010);
    add(1, 4'b0100, 0, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'h0011, 16'h0011);
    add(1, 4'b0100, 0, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'h0012, 16'h0012);
    add(0, 4'b0000, 0, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'h0013, 16'h0013);
    add(0, 4'b0000, 6, 0, 1, 0, 16'h0,    16'h0020, 9'h0,   16'h0013, 16'h0000);
    add(0, 4'b0000, 7, 0, 1, 0, 16'h0,    16'h0022, 9'h0,   16'h0013, 16'h0000);
    add(0, 4'b0001, 1, 0, 1, 0, 16'h0,    16'h0020, 9'h0,   16'h0000, 16'h0000);
    add(1, 4'b0101, 1, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'h0020, 16'h0020);
    add(1, 4'b0101, 1, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'h0021, 16'h0021);
    add(1, 4'b0101, 1, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'h0022, 16'h0022);
    add(1, 4'b0101, 1, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'h0020, 16'h0020);
    add(0, 4'b0001, 7, 0, 1, 0, 16'h0,    16'h0000, 9'h0,   16'h0021, 16'h0022);
    add(0, 4'b0001, 1, 0, 1, 0, 16'h0,    16'h0022, 9'h0,   16'h0021, 16'h0021);
    add(1, 4'b0101, 1, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'h0022, 16'h0022);
    add(0, 4'b0001, 1, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'h0023, 16'h0023);
    add(0, 4'b0010, 4, 0, 1, 0, 16'h0,    16'hFFFE, 9'h0,   16'h0000, 16'h0000);
    add(0, 4'b0010, 2, 0, 1, 0, 16'h0,    16'h0001, 9'h0,   16'h0000, 16'h0000);
    add(1, 4'b1110, 2, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'h0001, 16'h0001);
    add(0, 4'b0010, 2, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'hFFFF, 16'hFFFF);
    add(0, 4'b0011, 3, 0, 1, 0, 16'h0,    16'h0000, 9'h0,   16'h0000, 16'h0000);
    add(1, 4'b1011, 3, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'h0000, 16'h0000);
    add(0, 4'b0011, 3, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'hFFFF, 16'hFFFF);
    add(0, 4'b0000, 0, 0, 1, 0, 16'h0,    16'h0005, 9'h0,   16'h0013, 16'h0013);
    add(1, 4'b0100, 0, 0, 0, 1, 16'h0,    16'h0,    9'h1FF, 16'h0005, 16'h0005);
    add(0, 4'b0000, 0, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'h01FF, 16'h01FF);
    add(0, 4'b0000, 0, 0, 1, 0, 16'h0,    16'h0005, 9'h0,   16'h01FF, 16'h01FF);
    add(1, 4'b0100, 1, 0, 0, 1, 16'h0,    16'h0,    9'h009, 16'h0005, 16'h0023);
    add(0, 4'b0000, 1, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'h0006, 16'h0009);
    add(0, 4'b0000, 5, 1, 1, 1, 16'h5555, 16'hAAAA, 9'h003, 16'h0006, 16'h0000);
    add(0, 4'b0000, 5, 1, 0, 1, 16'h5555, 16'h0,    9'h003, 16'h0006, 16'hAAAA);
    add(0, 4'b0000, 5, 0, 0, 1, 16'h0,    16'h0,    9'h007, 16'h0006, 16'h5555);
    add(0, 4'b0000, 5, 0, 0, 0, 16'h0,    16'h0,    9'h0,   16'h0006, 16'h0007);

    foreach (tv[i]) begin
      drive(1, tv[i].acc, tv[i].y, tv[i].rf, tv[i].rl, tv[i].il, tv[i].sl,
            tv[i].rd, tv[i].li, tv[i].si);
      #1;
      $display("vec %0d: y=%b rf=%0d addr=%h dout=%h", i, tv[i].y, tv[i].rf, ram_addr, reg_dout);
      chk($sformatf("vec%0d ram_addr", i), ram_addr, tv[i].ea);
      chk($sformatf("vec%0d reg_dout", i), reg_dout, tv[i].ed);
      tick();
    end

    // cen=0 freezes everything, even with access and load requested
    drive(1, 0, 4'b0000, 3'd0, 0, 1, 0, 16'h0, 16'h0100, 9'h0);
    tick();
    drive(0, 1, 4'b0100, 3'd0, 0, 1, 0, 16'h0, 16'h1234, 9'h0);
    tick();
    tick();
    drive(0, 0, 4'b0000, 3'd0, 0, 0, 0, 16'h0, 16'h0, 9'h0);
    #1;
    $display("cen0: r0=%h addr=%h", reg_dout, ram_addr);
    chk("cen0 r0", reg_dout, 16'h0100);
    chk("cen0 addr", ram_addr, 16'h0100);

    // Reset with a simultaneous load must still clear
    drive(1, 1, 4'b0100, 3'd0, 0, 1, 0, 16'h0, 16'hBEEF, 9'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1, 0, 4'b0000, 3'd0, 0, 0, 0, 16'h0, 16'h0, 9'h0);
    $display("rst+load: checking all registers cleared");
    check_all_zero("rst_load");

    // Randomized traffic against the reference model
    model_reset();
    for (int n = 0; n < 600; n++) begin
      logic [15:0] v1, v2;
      v1 = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      v2 = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      drive($urandom_range(0, 9) != 0, 1'($urandom), 4'($urandom), 3'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            v1, v2, 9'($urandom));
      rst = ($urandom_range(0, 99) == 0);
      #1;
      chk($sformatf("rnd%0d ram_addr", n), ram_addr, m[y_field[1:0]]);
      chk($sformatf("rnd%0d reg_dout", n), reg_dout, m[r_field]);
      @(posedge clk);
      model_edge();
      #1;
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
